mips_data_mem_responder: RTL and testbench
==========================================

Name: mips_data_mem_responder

Overview:
- Data-side memory responder for the Harvard MIPS CPU's data bus; it is the slave end that answers the CPU's data_read/data_write requests.
- Reads are combinational; writes are single-cycle on the rising clock edge.
- After reset, a clear engine zero-fills the array and a preload port lets benches and top-levels seed contents.
- Sticky error flags and a write counter support self-checking benches.

Parameters:
ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^ADDR_W.
CNT_W, 16, width of the write counter.

Ports:
clk  input  1  Rising-edge clock.
reset  input  1  Asynchronous, active-low reset (asserted when 0).
data_address  input  32  CPU byte address.
data_read  input  1  CPU read request.
data_write  input  1  CPU write request.
data_writedata  input  32  CPU write data.
data_readdata  output  32  Read data, combinational.
init_mem  input  1  Preload write strobe.
init_mem_addr  input  32  Preload byte address.
init_data  input  32  Preload write data.
mem_ready  output  1  High once the clear sequence has finished.
err_range  output  1  Sticky: an access fell outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_W).
err_align  output  1  Sticky: an access had address[1:0] != 0.
err_rw  output  1  Sticky: data_read and data_write were both high in the same cycle.
write_count  output  CNT_W  Count of accepted CPU writes; saturates at all-ones.

Behaviour:
- Index computation: idx = (addr - BASE_ADDR) >> 2, truncated to ADDR_W bits. An address is in range iff (addr - BASE_ADDR) < 4*2^ADDR_W, using unsigned 32-bit arithmetic.
- Reset (reset==0, asynchronous):
  - State goes to CLEAR, clear counter to 0.
  - mem_ready=0; err_range, err_align and err_rw cleared to 0; write_count=0.
  - Array contents are not touched by reset itself.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
  - After writing index 2^ADDR_W-1, go to READY. CLEAR lasts exactly 2^ADDR_W cycles after reset release.
  - READY: terminal state; stays there until the next reset.
  - Reset asserted mid-CLEAR restarts the clear from index 0.
- mem_ready: registered, 1 exactly in READY.
- Read path, combinational:
  - data_readdata = mem[idx] when data_read && in-range && aligned && READY; otherwise 32'h0.
  - A write in cycle N is visible to a read from cycle N+1. A read in the same cycle as the write returns the old data.
- CPU write: mem[idx] <= data_writedata at the clock edge when all of these hold: data_write, in-range, aligned, READY, and !init_mem.
- Preload:
  - When init_mem && READY && init_mem_addr in-range and aligned, mem[idx(init_mem_addr)] <= init_data.
  - Preload has priority over a simultaneous CPU write; the CPU write is dropped and not counted.
  - init_mem during CLEAR is ignored.
- Errors:
  - Flags are evaluated only in READY and set on the clock edge; each stays set until reset.
  - err_range / err_align: set when a CPU request (data_read or data_write) or init_mem violates the range or alignment rule. Violating accesses have no side effects.
  - err_rw: set when data_read && data_write in the same cycle. The write still proceeds if otherwise legal.
- write_count: increments on every accepted CPU write; saturates at the all-ones value. Preload writes are not counted.
- Requests during CLEAR are ignored with no error flags and return read data 0.

Optional Feature:
MEM_BYTEENABLE_EN
- Defined: adds input port data_byteenable [3:0]. A CPU write updates only byte lanes whose enable bit is 1; lane 0 = bits 7:0.
  - A write with data_byteenable==4'b0000 is legal, changes no data, and is not counted.
  - Read data is unaffected by byteenable.
  - Preload always writes all four bytes.
- Undefined: no data_byteenable port; every write is a full word.

Decomposition:
- Package mips_mem_pkg holds:
  - the FSM state enum (CLEAR, READY);
  - word-size constants: WORD_BYTES=4, byte-offset width 2;
  - a function computing in-range and index from addr, BASE_ADDR and ADDR_W.
- One sub-module, mips_mem_array: a 2^ADDR_W x 32 storage array with one write port carrying per-byte write enable and one combinational read port.
- The responder owns the FSM, arbitration, error flags and counter.

Test Plan:
1. Clear and ready: release reset → mem_ready stays 0 for 1024 cycles, then 1. A read of 32'h0000_0010 then returns 32'h0 (with memory prefilled via preload before a second reset).
2. Write then read: write 32'hDEADBEEF to address 32'h0000_0008 → a same-cycle read returns the old value 0; the next cycle returns DEADBEEF. write_count==1.
3. Range and alignment: write to 32'h0000_1000 (ADDR_W=10) → err_range=1 and no array change. Read of 32'h0000_0006 → err_align=1 and readdata 0. A reset clears both flags.
4. Preload collision: in the same cycle, init_mem writes 32'h11111111 to 0x20 and the CPU writes 32'h22222222 to 0x24 → 0x20 holds 11111111, 0x24 is unchanged, write_count is unchanged.
5. Reset mid-clear: assert reset at clear cycle 500, release → mem_ready rises exactly 1024 cycles after release; read_write collision (data_read=data_write=1) in READY → err_rw=1 and the write still lands.
6. Byteenable (MEM_BYTEENABLE_EN): word at 0x0 = 32'h12345678; write 32'hAABBCCDD with byteenable 4'b0101 → reads 32'h12BB56DD; byteenable 4'b0000 leaves data and write_count unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and helpers for the MIPS data-side memory responder.
//   - mem_state_t   : responder FSM states (CLEAR while zero-filling, READY after)
//   - WORD_BYTES    : bytes per 32-bit word
//   - BYTE_OFF_W    : width of the byte offset inside a word
//   - addr_in_range : true when a byte address falls inside the mapped window
//   - addr_word_idx : word index of a byte address relative to the window base
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = 2;

  // The window spans WORD_BYTES * 2^addr_w bytes starting at base. Unsigned
  // wrap-around of (addr - base) makes addresses below base look huge, so a
  // single compare covers both ends. The span is held in 33 bits so a window
  // that covers the whole 32-bit space does not overflow.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned addr_w);
    logic [31:0] off;
    logic [32:0] span;
    off  = addr - base;
    span = 33'(WORD_BYTES) << addr_w;
    return {1'b0, off} < span;
  endfunction

  // Full-width word index; callers truncate to their own index width.
  function automatic logic [31:0] addr_word_idx(input logic [31:0] addr,
                                                input logic [31:0] base);
    return (addr - base) >> BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// ---------------------------------------------------------------------------
// mips_mem_array
// 2^ADDR_W x 32-bit storage with one byte-enabled synchronous write port and
// one combinational read port. Contents are never reset.
// Ports:
//   clk      : rising-edge clock for the write port
//   i_we     : write strobe
//   i_be     : per-byte lane enable, lane 0 = bits 7:0
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_raddr  : read word index
//   o_rdata  : read data (combinational, reflects writes from earlier edges)
// ---------------------------------------------------------------------------
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_data_mem_responder.sv
// ---------------------------------------------------------------------------
// mips_data_mem_responder
// Slave end of the Harvard MIPS CPU data bus. After reset it zero-fills the
// array (CLEAR), then serves combinational reads and single-cycle writes
// (READY). A preload port seeds contents; sticky flags record bad accesses
// and a saturating counter tracks accepted CPU writes.
// Optional build macro: MEM_BYTEENABLE_EN adds data_byteenable[3:0] so CPU
// writes update only the enabled byte lanes; without it writes are full word.
// Ports:
//   clk, reset (async, active-low)
//   data_address/data_read/data_write/data_writedata : CPU request
//   data_byteenable (MEM_BYTEENABLE_EN only)         : CPU byte lanes
//   data_readdata                                    : combinational read data
//   init_mem/init_mem_addr/init_data                 : preload write
//   mem_ready                                        : clear sequence done
//   err_range/err_align/err_rw                       : sticky error flags
//   write_count                                      : accepted CPU writes
// ---------------------------------------------------------------------------
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      data_address,
  input  logic             data_read,
  input  logic             data_write,
  input  logic [31:0]      data_writedata,
`ifdef MEM_BYTEENABLE_EN
  input  logic [3:0]       data_byteenable,
`endif
  output logic [31:0]      data_readdata,
  input  logic             init_mem,
  input  logic [31:0]      init_mem_addr,
  input  logic [31:0]      init_data,
  output logic             mem_ready,
  output logic             err_range,
  output logic             err_align,
  output logic             err_rw,
  output logic [CNT_W-1:0] write_count
);

  mem_state_t         r_state;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic               r_mem_ready;
  logic               r_err_range;
  logic               r_err_align;
  logic               r_err_rw;
  logic [CNT_W-1:0]   r_write_count;

  logic               w_cpu_in_range;
  logic               w_cpu_aligned;
  logic [ADDR_W-1:0]  w_cpu_idx;
  logic               w_init_in_range;
  logic               w_init_aligned;
  logic [ADDR_W-1:0]  w_init_idx;
  logic               w_ready;
  logic               w_init_ok;
  logic               w_cpu_wr_ok;
  logic               w_cpu_count;
  logic [3:0]         w_cpu_be;
  logic               w_range_viol;
  logic               w_align_viol;

  logic               w_we;
  logic [3:0]         w_be;
  logic [ADDR_W-1:0]  w_waddr;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rdata;

`ifdef MEM_BYTEENABLE_EN
  assign w_cpu_be = data_byteenable;
`else
  assign w_cpu_be = 4'hF;
`endif

  assign w_ready         = (r_state == READY);
  assign w_cpu_in_range  = addr_in_range(data_address, BASE_ADDR, ADDR_W);
  assign w_cpu_aligned   = (data_address[BYTE_OFF_W-1:0] == '0);
  assign w_cpu_idx       = ADDR_W'(addr_word_idx(data_address, BASE_ADDR));
  assign w_init_in_range = addr_in_range(init_mem_addr, BASE_ADDR, ADDR_W);
  assign w_init_aligned  = (init_mem_addr[BYTE_OFF_W-1:0] == '0);
  assign w_init_idx      = ADDR_W'(addr_word_idx(init_mem_addr, BASE_ADDR));

  // Any init_mem strobe, even an illegal one, blocks the CPU write that cycle.
  assign w_init_ok   = init_mem && w_ready && w_init_in_range && w_init_aligned;
  assign w_cpu_wr_ok = data_write && w_ready && w_cpu_in_range && w_cpu_aligned && !init_mem;
  assign w_cpu_count = w_cpu_wr_ok && (w_cpu_be != 4'h0);

  assign w_range_viol = ((data_read || data_write) && !w_cpu_in_range) ||
                        (init_mem && !w_init_in_range);
  assign w_align_viol = ((data_read || data_write) && !w_cpu_aligned) ||
                        (init_mem && !w_init_aligned);

  // Single write port shared by the clear engine, preload and CPU writes.
  always_comb begin
    w_we    = 1'b0;
    w_be    = 4'h0;
    w_waddr = w_cpu_idx;
    w_wdata = data_writedata;
    if (!w_ready) begin
      w_we    = 1'b1;
      w_be    = 4'hF;
      w_waddr = r_clr_cnt;
      w_wdata = 32'h0;
    end else if (w_init_ok) begin
      w_we    = 1'b1;
      w_be    = 4'hF;
      w_waddr = w_init_idx;
      w_wdata = init_data;
    end else if (w_cpu_wr_ok) begin
      w_we    = 1'b1;
      w_be    = w_cpu_be;
      w_waddr = w_cpu_idx;
      w_wdata = data_writedata;
    end
  end

  mips_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_cpu_idx),
    .o_rdata (w_rdata)
  );

  assign data_readdata = (data_read && w_ready && w_cpu_in_range && w_cpu_aligned)
                         ? w_rdata : 32'h0;

  // FSM, sticky flags and write counter. mem_ready is set on the same edge
  // that moves the FSM into READY so it mirrors the state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= CLEAR;
      r_clr_cnt     <= '0;
      r_mem_ready   <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_align   <= 1'b0;
      r_err_rw      <= 1'b0;
      r_write_count <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == {ADDR_W{1'b1}}) begin
            r_state     <= READY;
            r_mem_ready <= 1'b1;
          end
        end
        READY: begin
          if (w_range_viol)             r_err_range <= 1'b1;
          if (w_align_viol)             r_err_align <= 1'b1;
          if (data_read && data_write)  r_err_rw    <= 1'b1;
          if (w_cpu_count && (r_write_count != {CNT_W{1'b1}})) begin
            r_write_count <= r_write_count + 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign mem_ready   = r_mem_ready;
  assign err_range   = r_err_range;
  assign err_align   = r_err_align;
  assign err_rw      = r_err_rw;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Bench for mips_data_mem_responder. Stimulus tasks queue expected results;
// a monitor on the falling edge pops and compares whenever a read is
// presented or a status probe is raised.
module tb_mips_data_mem_responder;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 3;

  localparam int K_READY = 0;
  localparam int K_RANGE = 1;
  localparam int K_ALIGN = 2;
  localparam int K_RW    = 3;
  localparam int K_COUNT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      data_address;
  logic             data_read;
  logic             data_write;
  logic [31:0]      data_writedata;
`ifdef MEM_BYTEENABLE_EN
  logic [3:0]       data_byteenable;
`endif
  logic [31:0]      data_readdata;
  logic             init_mem;
  logic [31:0]      init_mem_addr;
  logic [31:0]      init_data;
  logic             mem_ready;
  logic             err_range;
  logic             err_align;
  logic             err_rw;
  logic [CNT_W-1:0] write_count;

  logic             probe;
  int               testsRun    = 0;
  int               testsFailed = 0;

  logic [31:0] rdExpQ[$];
  string       rdNameQ[$];
  int          stKindQ[$];
  logic [31:0] stExpQ[$];
  string       stNameQ[$];

  always #5 clk = ~clk;

  mips_data_mem_responder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (32'h0000_0000),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_writedata  (data_writedata),
`ifdef MEM_BYTEENABLE_EN
    .data_byteenable (data_byteenable),
`endif
    .data_readdata   (data_readdata),
    .init_mem        (init_mem),
    .init_mem_addr   (init_mem_addr),
    .init_data       (init_data),
    .mem_ready       (mem_ready),
    .err_range       (err_range),
    .err_align       (err_align),
    .err_rw          (err_rw),
    .write_count     (write_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: reads are checked whenever the bench presents data_read, status
  // outputs whenever a probe is raised.
  always @(negedge clk) begin
    int          k;
    logic [31:0] e;
    logic [31:0] a;
    string       n;
    if (reset && data_read) begin
      if (rdExpQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_read: got %h, expected no read", data_readdata);
      end else begin
        e = rdExpQ.pop_front();
        n = rdNameQ.pop_front();
        checkOutput(n, data_readdata, e);
      end
    end
    if (probe) begin
      if (stKindQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_probe: got probe, expected none");
      end else begin
        k = stKindQ.pop_front();
        e = stExpQ.pop_front();
        n = stNameQ.pop_front();
        case (k)
          K_READY: a = {31'b0, mem_ready};
          K_RANGE: a = {31'b0, err_range};
          K_ALIGN: a = {31'b0, err_align};
          K_RW:    a = {31'b0, err_rw};
          default: a = 32'(write_count);
        endcase
        checkOutput(n, a, e);
      end
    end
  end

  task automatic idleInputs();
    data_address   = 32'h0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_writedata = 32'h0;
    init_mem       = 1'b0;
    init_mem_addr  = 32'h0;
    init_data      = 32'h0;
`ifdef MEM_BYTEENABLE_EN
    data_byteenable = 4'hF;
`endif
  endtask

  // One bus cycle; starts and ends just after a rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic init,
                               input logic [31:0] iaddr, input logic [31:0] idata,
                               input logic [31:0] expRead, input string name);
    data_read      = rd;
    data_write     = wr;
    data_address   = addr;
    data_writedata = wdata;
    init_mem       = init;
    init_mem_addr  = iaddr;
    init_data      = idata;
    if (rd && reset) begin
      rdExpQ.push_back(expRead);
      rdNameQ.push_back(name);
    end
    @(posedge clk);
    #1;
    idleInputs();
  endtask

`ifdef MEM_BYTEENABLE_EN
  task automatic applyByteWrite(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be);
    data_write      = 1'b1;
    data_address    = addr;
    data_writedata  = wdata;
    data_byteenable = be;
    @(posedge clk);
    #1;
    idleInputs();
  endtask
`endif

  task automatic expectStatus(input int kind, input logic [31:0] exp, input string name);
    stKindQ.push_back(kind);
    stExpQ.push_back(exp);
    stNameQ.push_back(name);
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic waitReady(input int expCycles, input string name);
    int n = 0;
    while (!mem_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n), 32'(expCycles));
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    probe = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    expectStatus(K_READY, 0, "rst_ready");
    expectStatus(K_RANGE, 0, "rst_range");
    expectStatus(K_ALIGN, 0, "rst_align");
    expectStatus(K_RW,    0, "rst_rw");
    expectStatus(K_COUNT, 0, "rst_count");
    reset = 1'b1;
    waitReady(1024, "clear_len_first");

    // Preload, then a second reset must zero-fill it again
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h10, 32'hCAFE_F00D, 32'h0, "preload_0x10");
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 32'h0, 32'h0, 32'hCAFE_F00D, "rd_preloaded");
    pulseReset();
    waitReady(1024, "clear_len_second");
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 32'h0, 32'h0, 32'h0, "rd_cleared");

    // Write then read; same-cycle read sees old data
    applyStimulus(1, 1, 32'h8, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 32'h0, "rd_same_cycle");
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, "rd_after_write");
    expectStatus(K_COUNT, 1, "count_one");
    expectStatus(K_RW,    1, "rw_flag_set");

    // Preload collides with a CPU write: preload wins, CPU write dropped
    applyStimulus(0, 1, 32'h24, 32'h2222_2222, 1, 32'h20, 32'h1111_1111, 32'h0, "collision");
    applyStimulus(1, 0, 32'h20, 32'h0, 0, 32'h0, 32'h0, 32'h1111_1111, "rd_preload_win");
    applyStimulus(1, 0, 32'h24, 32'h0, 0, 32'h0, 32'h0, 32'h0, "rd_cpu_dropped");
    expectStatus(K_COUNT, 1, "count_after_collision");

    // Range and alignment
    expectStatus(K_RANGE, 0, "range_clean");
    applyStimulus(0, 1, 32'h1000, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 32'h0, "wr_out_of_range");
    expectStatus(K_RANGE, 1, "range_set");
    expectStatus(K_ALIGN, 0, "align_clean");
    expectStatus(K_COUNT, 1, "count_no_range_wr");
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, "rd_no_alias");
    applyStimulus(1, 0, 32'h6, 32'h0, 0, 32'h0, 32'h0, 32'h0, "rd_misaligned");
    expectStatus(K_ALIGN, 1, "align_set");

    // Reset clears flags; reset mid-clear restarts the sequence
    reset = 1'b0;
    expectStatus(K_RANGE, 0, "rst2_range");
    expectStatus(K_ALIGN, 0, "rst2_align");
    expectStatus(K_RW,    0, "rst2_rw");
    expectStatus(K_COUNT, 0, "rst2_count");
    reset = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    expectStatus(K_READY, 0, "mid_clear_not_ready");
    pulseReset();
    repeat (10) @(posedge clk);
    #1;
    // Requests during CLEAR are ignored: no writes, no flags, read data 0
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h5555_5555, 32'h0, "init_during_clear");
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h2, 32'h5555_5555, 32'h0, "bad_init_during_clear");
    applyStimulus(0, 1, 32'h4, 32'h7777_7777, 0, 32'h0, 32'h0, 32'h0, "wr_during_clear");
    waitReady(1024 - 13, "clear_len_restart");
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, "rd_clear_ignored_init");
    applyStimulus(1, 0, 32'h4, 32'h0, 0, 32'h0, 32'h0, 32'h0, "rd_clear_ignored_wr");
    expectStatus(K_ALIGN, 0, "clear_no_align_err");
    expectStatus(K_COUNT, 0, "clear_no_count");

    // Read/write collision: flag set, write lands
    applyStimulus(1, 1, 32'h30, 32'h0BAD_F00D, 0, 32'h0, 32'h0, 32'h0, "rw_old_data");
    applyStimulus(1, 0, 32'h30, 32'h0, 0, 32'h0, 32'h0, 32'h0BAD_F00D, "rw_write_landed");
    expectStatus(K_RW,    1, "rw_collision_flag");
    expectStatus(K_COUNT, 1, "rw_counted");

`ifdef MEM_BYTEENABLE_EN
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h1234_5678, 32'h0, "be_preload");
    applyByteWrite(32'h0, 32'hAABB_CCDD, 4'b0101);
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h12BB_56DD, "be_partial");
    expectStatus(K_COUNT, 2, "be_counted");
    applyByteWrite(32'h0, 32'hFFFF_FFFF, 4'b0000);
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h12BB_56DD, "be_none_data");
    expectStatus(K_COUNT, 2, "be_none_count");
`endif

    // Counter saturation (CNT_W=3 saturates at 7)
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 32'h40 + 32'(4*i), 32'hA000_0000 + 32'(i), 0, 32'h0, 32'h0, 32'h0, "sat_write");
    end
    expectStatus(K_COUNT, 7, "count_saturated");
    applyStimulus(1, 0, 32'h5C, 32'h0, 0, 32'h0, 32'h0, 32'hA000_0007, "rd_last_sat_write");
    expectStatus(K_READY, 1, "ready_held");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queues_drained", 32'(rdExpQ.size() + stKindQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
